// File: rtl/fib_stream_checker.sv
// fib_stream_checker: consumes a valid/ready Fibonacci stream and verifies it
// against the 0,1-seeded recurrence, reporting the first mismatch and overflow.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : fib_stream_checker                                            |
// | Purpose  : In-system monitor for a Fibonacci generator output stream     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fib_stream_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_fib,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] err_index,
  output logic [WIDTH-1:0] err_expected,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow
);

  if (CNT_W < WIDTH) begin : g_bad_cnt_w
    $error("fib_stream_checker: CNT_W must be >= WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_n_lat;
  logic [WIDTH-1:0] r_prev1;
  logic [WIDTH-1:0] r_prev2;
  logic [CNT_W-1:0] r_term_count;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_err_index;
  logic [WIDTH-1:0] r_err_expected;
  logic             r_overflow;

  logic             w_run;
  logic             w_start;
  logic             w_accept;
  logic             w_n_zero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_last;

  assign w_run       = (r_state == S_RUN);
  assign w_start     = start && !w_run;
  assign w_accept    = in_valid && w_run;
  assign w_n_zero    = (n == '0);
  // Extra carry bit is the overflow indicator; the stored term wraps mod 2^WIDTH.
  assign w_sum       = {1'b0, r_prev1} + {1'b0, r_prev2};
  assign w_count_inc = r_term_count + CNT_W'(1);
  assign w_last      = (w_count_inc == CNT_W'(r_n_lat));
  assign w_match     = (in_fib == w_exp);

  always_comb begin
    w_exp = w_sum[WIDTH-1:0];
    if (r_term_count == '0) begin
      w_exp = '0;
    end else if (r_term_count == CNT_W'(1)) begin
      w_exp = WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          w_state_next = w_n_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (!w_match) begin
            w_state_next = S_FAIL;
          end else if (w_last) begin
            w_state_next = S_DONE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_lat        <= '0;
      r_prev1        <= '0;
      r_prev2        <= '0;
      r_term_count   <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_index    <= '0;
      r_err_expected <= '0;
      r_overflow     <= 1'b0;
    end else if (w_start) begin
      // Prev terms are zeroed so the adder cannot carry for k = 0 or 1.
      r_n_lat        <= n;
      r_prev1        <= '0;
      r_prev2        <= '0;
      r_term_count   <= '0;
      r_done         <= w_n_zero;
      r_error        <= 1'b0;
      r_err_index    <= '0;
      r_err_expected <= '0;
      r_overflow     <= 1'b0;
    end else if (w_accept) begin
      if (w_sum[WIDTH]) begin
        r_overflow <= 1'b1;
      end
      if (w_match) begin
        r_prev2      <= r_prev1;
        r_prev1      <= in_fib;
        r_term_count <= w_count_inc;
        if (w_last) begin
          r_done <= 1'b1;
        end
      end else begin
        r_error        <= 1'b1;
        r_err_index    <= r_term_count;
        r_err_expected <= w_exp;
      end
    end
  end

  assign in_ready     = w_run;
  assign busy         = w_run;
  assign done         = r_done;
  assign error        = r_error;
  assign err_index    = r_err_index;
  assign err_expected = r_err_expected;
  assign term_count   = r_term_count;
  assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fib_stream_checker.sv
// Directed bench for fib_stream_checker with a behavioural reference model.
`default_nettype none

module tb_fib_stream_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_fib = '0;
  logic       in_ready, busy, done, error, overflow;
  logic [7:0] err_index, err_expected, term_count;

  int total = 0;
  int passed = 0;

  fib_stream_checker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .in_valid(in_valid), .in_fib(in_fib), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .err_expected(err_expected), .term_count(term_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a run is either active or not; accepted terms kept in a history array.
  bit       m_run, m_done, m_err, m_ovf;
  int       m_n, m_count, m_idx, m_exp;
  int       hist[256];

  function automatic int fib_exp(int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    return (hist[k-1] + hist[k-2]) % 256;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_err <= 0; m_ovf <= 0;
      m_n <= 0; m_count <= 0; m_idx <= 0; m_exp <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_n <= int'(n); m_count <= 0; m_err <= 0; m_idx <= 0; m_exp <= 0; m_ovf <= 0;
        m_done <= (n == 0);
        m_run  <= (n != 0);
      end
    end else if (in_valid) begin
      if (m_count >= 2 && hist[m_count-1] + hist[m_count-2] > 255) m_ovf <= 1;
      if (int'(in_fib) == fib_exp(m_count)) begin
        hist[m_count] <= int'(in_fib);
        m_count <= m_count + 1;
        if (m_count + 1 == m_n) begin
          m_run <= 0; m_done <= 1;
        end
      end else begin
        m_run <= 0; m_err <= 1; m_idx <= m_count; m_exp <= fib_exp(m_count);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, m_run);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("term_count", term_count, m_count);
      chk("overflow", overflow, m_ovf);
      chk("err_index", err_index, m_idx);
      chk("err_expected", err_expected, m_exp);
    end
  end

  task automatic cyc(input logic s, input logic [7:0] nn, input logic v, input logic [7:0] f);
    start = s; n = nn; in_valid = v; in_fib = f;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_cnt"}, term_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_idx"}, err_index, 0);
    chk({tag, "_exp"}, err_expected, 0);
  endtask

  logic [7:0] seq [15];

  initial begin
    seq = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
            8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean run of 7 terms
    cyc(1, 8'd7, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'd7, 1, seq[i]);
    chk("t1_done", done, 1);
    chk("t1_cnt", term_count, 7);
    chk("t1_err", error, 0);
    chk("t1_ovf", overflow, 0);
    chk("t1_rdy", in_ready, 0);

    // Mismatch at k=4 (4 instead of 3), then ignored beats
    cyc(1, 8'd7, 0, 0);
    cyc(0, 8'd7, 1, 8'd0);
    cyc(0, 8'd7, 1, 8'd1);
    cyc(0, 8'd7, 1, 8'd1);
    cyc(0, 8'd7, 1, 8'd2);
    cyc(0, 8'd7, 1, 8'd4);
    chk("t2_err", error, 1);
    chk("t2_idx", err_index, 4);
    chk("t2_exp", err_expected, 3);
    chk("t2_cnt", term_count, 4);
    chk("t2_rdy", in_ready, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'd7, 1, 8'd5);
    chk("t2_cnt_hold", term_count, 4);

    // Wrapping run of 15 terms
    cyc(1, 8'd15, 0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 8'd15, 1, seq[i]);
    chk("t3_ovf_pre", overflow, 0);
    cyc(0, 8'd15, 1, seq[14]);
    chk("t3_done", done, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_err", error, 0);
    chk("t3_cnt", term_count, 15);

    // First term wrong
    cyc(1, 8'd3, 0, 0);
    cyc(0, 8'd3, 1, 8'd5);
    chk("t4_err", error, 1);
    chk("t4_idx", err_index, 0);
    chk("t4_exp", err_expected, 0);
    chk("t4_ovf_cleared", overflow, 0);

    // n = 0
    cyc(1, 8'd0, 0, 0);
    chk("t5_done", done, 1);
    chk("t5_rdy", in_ready, 0);
    cyc(0, 8'd0, 1, 8'd0);
    chk("t5_cnt", term_count, 0);

    // Stalls plus ignored mid-run start
    cyc(1, 8'd5, 0, 0);
    cyc(0, 8'd5, 1, 8'd0);
    cyc(0, 8'd5, 0, 8'd9);
    cyc(0, 8'd5, 1, 8'd1);
    cyc(1, 8'd2, 0, 0);
    cyc(0, 8'd5, 0, 0);
    chk("t6_busy", busy, 1);
    chk("t6_cnt_mid", term_count, 2);
    cyc(0, 8'd5, 1, 8'd1);
    cyc(0, 8'd5, 0, 0);
    cyc(0, 8'd5, 1, 8'd2);
    cyc(0, 8'd5, 1, 8'd3);
    chk("t6_done", done, 1);
    chk("t6_cnt", term_count, 5);

    // Asynchronous reset in the middle of a run
    cyc(1, 8'd7, 0, 0);
    cyc(0, 8'd7, 1, 8'd0);
    cyc(0, 8'd7, 1, 8'd1);
    cyc(0, 8'd7, 1, 8'd1);
    #2 rst = 1'b1;
    #1 all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc(1, 8'd2, 0, 0);
    cyc(0, 8'd2, 1, 8'd0);
    cyc(0, 8'd2, 1, 8'd1);
    chk("t7_done", done, 1);
    chk("t7_cnt", term_count, 2);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
